// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control bus between the multicycle controller and its datapath
interface mc_control_fsm_if;
  // datapath -> controller
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       ecall_halt;
  logic       mem_ready;
  // controller -> datapath
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       mem_to_reg;
  logic       pc_to_reg;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op_sel;
  logic [1:0] pc_source;
  logic       is_halted;
  logic       mem_timeout;
  logic       illegal_inst;
  logic [2:0] state;

  // controller side
  modport master (
    input  opcode, alu_bcond, ecall_halt, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
           mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op_sel, pc_source,
           is_halted, mem_timeout, illegal_inst, state
  );

  // datapath side
  modport slave (
    output opcode, alu_bcond, ecall_halt, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write, i_or_d,
           mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op_sel, pc_source,
           is_halted, mem_timeout, illegal_inst, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle RV32I control FSM with memory wait counter and watchdog
module mc_control_fsm #(
  parameter int MEM_LAT_FIXED = 0,
  parameter int TIMEOUT_W     = 8
) (
  input logic              clk,
  input logic              reset,
  mc_control_fsm_if.master bus
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  // Counter must hold both the fixed-latency terminal value and the watchdog limit.
  localparam int LAT_W = (MEM_LAT_FIXED > 1) ? $clog2(MEM_LAT_FIXED) : 1;
  localparam int CNT_W = (TIMEOUT_W > LAT_W) ? TIMEOUT_W : LAT_W;
  localparam logic [CNT_W-1:0] LAT_LAST = (MEM_LAT_FIXED > 0) ? CNT_W'(MEM_LAT_FIXED - 1) : '0;
  // The counter holds cycles already waited, so the wait gives up after
  // 2^TIMEOUT_W-1 cycles, i.e. in the cycle where the count is one below that.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((1 << TIMEOUT_W) - 2);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             tmo_q, tmo_d;

  logic       mem_done, wd_hit, is_load;
  logic       pc_write_c, ir_write_c, reg_write_c, mem_read_c, mem_write_c;
  logic       i_or_d_c, mem_to_reg_c, pc_to_reg_c;
  logic [1:0] src_a_c, src_b_c, op_c, pc_src_c;

  assign mem_done = (MEM_LAT_FIXED == 0) ? bus.mem_ready : (cnt_q == LAT_LAST);
  assign wd_hit   = (MEM_LAT_FIXED == 0) && (cnt_q == WD_LAST);
  assign is_load  = (bus.opcode == OP_LOAD);

  // Next-state, counter, sticky-flag and control-output decode for the current state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    ill_d        = ill_q;
    tmo_d        = tmo_q;
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    i_or_d_c     = 1'b0;
    mem_to_reg_c = 1'b0;
    pc_to_reg_c  = 1'b0;
    src_a_c      = 2'b00;
    src_b_c      = 2'b00;
    op_c         = 2'b00;
    pc_src_c     = 2'b00;
    case (state_q)
      S_IF: begin
        mem_read_c = 1'b1;
        if (mem_done) begin
          ir_write_c = 1'b1;
          state_d    = S_ID;
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ID: begin
        // ALUOut captures PC+imm for branches and JAL.
        src_b_c = 2'b01;
        case (bus.opcode)
          OP_ECALL: begin
            if (bus.ecall_halt) begin
              state_d = S_HALT;
            end else begin
              pc_write_c = 1'b1;
              state_d    = S_IF;
            end
          end
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
            state_d = S_EX;
          default: begin
            ill_d   = 1'b1;
            state_d = S_ERR;
          end
        endcase
      end
      S_EX: begin
        case (bus.opcode)
          OP_R: begin
            src_a_c = 2'b01; op_c = 2'b10; state_d = S_WB;
          end
          OP_I: begin
            src_a_c = 2'b01; src_b_c = 2'b01; op_c = 2'b10; state_d = S_WB;
          end
          OP_LUI: begin
            src_a_c = 2'b10; src_b_c = 2'b01; state_d = S_WB;
          end
          OP_AUIPC: begin
            src_b_c = 2'b01; state_d = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            src_a_c = 2'b01; src_b_c = 2'b01; state_d = S_MEM;
          end
          OP_BR: begin
            src_a_c    = 2'b01;
            op_c       = 2'b01;
            pc_write_c = 1'b1;
            pc_src_c   = bus.alu_bcond ? 2'b01 : 2'b00;
            state_d    = S_IF;
          end
          OP_JAL: begin
            reg_write_c = 1'b1; pc_to_reg_c = 1'b1;
            pc_write_c  = 1'b1; pc_src_c    = 2'b01;
            state_d     = S_IF;
          end
          OP_JALR: begin
            src_a_c     = 2'b01; src_b_c     = 2'b01;
            reg_write_c = 1'b1;  pc_to_reg_c = 1'b1;
            pc_write_c  = 1'b1;  pc_src_c    = 2'b10;
            state_d     = S_IF;
          end
          default: begin
            // Opcode changed after decode; nothing sensible to execute.
            ill_d   = 1'b1;
            state_d = S_ERR;
          end
        endcase
      end
      S_MEM: begin
        i_or_d_c    = 1'b1;
        mem_read_c  = is_load;
        mem_write_c = !is_load;
        if (mem_done) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_write_c = 1'b1;
            state_d    = S_IF;
          end
        end else if (wd_hit) begin
          tmo_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_load;
        pc_write_c   = 1'b1;
        state_d      = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_ERR;
    endcase
  end

  // State, wait counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
    end
  end

  // Write/access strobes are held off for as long as reset is asserted.
  assign bus.pc_write     = reset & pc_write_c;
  assign bus.ir_write     = reset & ir_write_c;
  assign bus.reg_write    = reset & reg_write_c;
  assign bus.mem_read     = reset & mem_read_c;
  assign bus.mem_write    = reset & mem_write_c;
  assign bus.i_or_d       = i_or_d_c;
  assign bus.mem_to_reg   = mem_to_reg_c;
  assign bus.pc_to_reg    = pc_to_reg_c;
  assign bus.alu_src_a    = src_a_c;
  assign bus.alu_src_b    = src_b_c;
  assign bus.alu_op_sel   = op_c;
  assign bus.pc_source    = pc_src_c;
  assign bus.is_halted    = (state_q == S_HALT) || (state_q == S_ERR);
  assign bus.mem_timeout  = tmo_q;
  assign bus.illegal_inst = ill_q;
  assign bus.state        = state_q;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_LAT_FIXED, default 0; 0 means memory completion comes from mem_ready, and N>0 means memory completes a fixed N cycles after it is entered.
REQ-002 Parameter TIMEOUT_W, default 8; width of the mem_ready watchdog counter, so the limit is 2^TIMEOUT_W-1 cycles.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-005 opcode  in  7  instruction[6:0] from the instruction register.
REQ-006 alu_bcond  in  1  branch-condition result from the ALU, valid in EX.
REQ-007 ecall_halt  in  1  external compare result: x17==10.
REQ-008 mem_ready  in  1  memory completion; ignored when MEM_LAT_FIXED>0.
REQ-009 pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  write and access strobes.
REQ-010 i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 mem_to_reg, pc_to_reg  out  1 each  writeback selects: memory data, or PC+4.
REQ-012 alu_src_a  out  2  ALU A select: 00=PC, 01=rs1, 10=zero.
REQ-013 alu_src_b  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4.
REQ-014 alu_op_sel  out  2  ALU operation: 00=add, 01=branch compare, 10=funct-decoded.
REQ-015 pc_source  out  2  next-PC select: 00=PC+4 (external adder), 01=ALUOut register, 10=live ALU result.
REQ-016 is_halted, mem_timeout, illegal_inst  out  1 each  status flags.
REQ-017 state  out  3  current state encoding, for debug.

Function
REQ-018 States and encodings SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6; value 7 SHALL go to ERR.
REQ-019 Outputs SHALL be combinational from state, opcode, alu_bcond and mem-done; every output not stated for a state SHALL be 0.
REQ-020 mem-done SHALL be mem_ready when MEM_LAT_FIXED=0; otherwise it SHALL be true when the wait counter equals MEM_LAT_FIXED-1, so the state lasts exactly MEM_LAT_FIXED cycles.
REQ-021 The wait counter SHALL clear on entry to IF or MEM and increment each cycle spent waiting in that state.
REQ-022 IF: mem_read=1 and i_or_d=0 while waiting; on mem-done, ir_write=1 and the next state is ID.
REQ-023 ID: alu_src_a=00, alu_src_b=01, alu_op_sel=00, so that ALUOut captures PC+imm.
REQ-024 ID with ECALL (1110011): if ecall_halt=1 the next state is HALT with pc_write=0; otherwise pc_write=1, pc_source=00, and the next state is IF.
REQ-025 ID with an opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011}: next state ERR and illegal_inst is set.
REQ-026 ID with any other legal opcode: next state EX.
REQ-027 EX, R-type: src_a=01, src_b=00, op=10, next state WB.
REQ-028 EX, I-arith: src_a=01, src_b=01, op=10, next state WB.
REQ-029 EX, LUI: src_a=10, src_b=01, op=00, next state WB.
REQ-030 EX, AUIPC: src_a=00, src_b=01, op=00, next state WB.
REQ-031 EX, LOAD/STORE: src_a=01, src_b=01, op=00, next state MEM.
REQ-032 EX, BRANCH: src_a=01, src_b=00, op=01, pc_write=1, pc_source = alu_bcond ? 01 : 00, next state IF.
REQ-033 EX, JAL: reg_write=1, pc_to_reg=1, pc_write=1, pc_source=01, next state IF.
REQ-034 EX, JALR: src_a=01, src_b=01, op=00, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=10, next state IF.
REQ-035 MEM: i_or_d=1, with mem_read=1 (LOAD) or mem_write=1 (STORE) held for the whole wait.
REQ-036 MEM on mem-done: LOAD goes to WB; STORE asserts pc_write=1 with pc_source=00 and goes to IF.
REQ-037 WB: reg_write=1, mem_to_reg=(opcode==LOAD), pc_write=1, pc_source=00, next state IF.
REQ-038 pc_write SHALL assert in exactly one cycle per retired instruction.
REQ-039 Watchdog (MEM_LAT_FIXED=0 only): when the counter reaches 2^TIMEOUT_W-1 in IF or MEM without mem_ready, the next state is ERR and mem_timeout is set; mem_ready on that same cycle wins and there is no timeout.
REQ-040 HALT and ERR are absorbing until reset; is_halted=1 in both; illegal_inst and mem_timeout are sticky.

Reset
REQ-041 A rising edge of clk with reset=0 SHALL force state=IF, counter=0, and all flags=0.
REQ-042 While reset=0, pc_write, ir_write, reg_write, mem_read and mem_write SHALL be 0 combinationally.
REQ-043 Reset SHALL override mid-wait, HALT and ERR.

Verification
REQ-044 Handshake mode, mem_ready=1 constant, opcode=0110011: states IF,ID,EX,WB,IF; one reg_write in WB, one pc_write with source 00.
REQ-045 LOAD with mem_ready low for 2 cycles in MEM: states IF,ID,EX,MEM,MEM,MEM,WB; mem_read=1 for all 3 MEM cycles; mem_to_reg=1 in WB.
REQ-046 BRANCH with alu_bcond=1, then again with 0: 3-cycle instruction; pc_source=01, then 00.
REQ-047 MEM_LAT_FIXED=3 with mem_ready tied 0: IF lasts exactly 3 cycles and ir_write pulses once in the 3rd.
REQ-048 TIMEOUT_W=3, mem_ready=0 in IF: ERR entered after 7 cycles in IF; mem_timeout=1 and is_halted=1; reset=0 for one edge returns state to IF with flags cleared.
REQ-049 ECALL with ecall_halt=1: HALT reached from ID with no pc_write; opcode=1111111 drives ERR with illegal_inst=1.
